// File: rtl/hack_loader_pkg.sv
// Shared definitions for the HACK program loader: command bytes and FSM states.
package hack_loader_pkg;

  localparam logic [7:0] CMD_INS  = 8'h49;  // 'I'
  localparam logic [7:0] CMD_DATA = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_CLR  = 8'h43;  // 'C'

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY_HI,
    S_PAY_LO,
    S_WRITE,
    S_CLEAR
  } state_t;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_INS) || (b == CMD_DATA);
  endfunction

endpackage

// File: rtl/hack_loader.sv
// Framed byte-stream loader: writes 16-bit words into HACK instruction/data
// memory and drives the computer's memory-clear and run/halt controls.
module hack_loader
  import hack_loader_pkg::*;
#(
  parameter int CLR_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        ins_memfull,
  input  logic        data_memfull,
  output logic        write_ins,
  output logic [15:0] addr_ins,
  output logic [15:0] dati_ins,
  output logic        write_data,
  output logic [15:0] addr_data,
  output logic [15:0] dati_data,
  output logic        mem_clr_n,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        error
);

  localparam int             CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0]  CLR_LAST = CW'(CLR_CYCLES - 1);

  state_t        r_state, w_next;
  logic [1:0]    r_hdr_idx;
  logic          r_is_data;
  logic [15:0]   r_addr, r_cnt;
  logic [7:0]    r_hi;
  logic [CW-1:0] r_clr_cnt;
  logic          r_cpu_run, r_error;
  logic [15:0]   r_addr_ins, r_dati_ins, r_addr_data, r_dati_data;

  assign addr_ins    = r_addr_ins;
  assign dati_ins    = r_dati_ins;
  assign addr_data   = r_addr_data;
  assign dati_data   = r_dati_data;
  assign cpu_reset_n = r_cpu_run;
  assign error       = r_error;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default first so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    rx_ready   = 1'b0;
    write_ins  = 1'b0;
    write_data = 1'b0;
    mem_clr_n  = 1'b1;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (is_load_cmd(rx_data))  w_next = S_HDR;
          else if (rx_data == CMD_CLR) w_next = S_CLEAR;
        end
      end
      S_HDR: begin
        rx_ready = 1'b1;
        if (rx_valid && r_hdr_idx == 2'd3)
          w_next = ({r_cnt[15:8], rx_data} == 16'd0) ? S_IDLE : S_PAY_HI;
      end
      S_PAY_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = S_PAY_LO;
      end
      S_PAY_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        write_ins  = !r_is_data && !ins_memfull;
        write_data =  r_is_data && !data_memfull;
        w_next     = (r_cnt == 16'd1) ? S_IDLE : S_PAY_HI;
      end
      S_CLEAR: begin
        mem_clr_n = 1'b0;
        if (r_clr_cnt == '0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Outputs sit at their reset values while reset_n is low, even before the edge.
    if (!reset_n) begin
      w_next     = S_IDLE;
      rx_ready   = 1'b0;
      write_ins  = 1'b0;
      write_data = 1'b0;
      mem_clr_n  = 1'b1;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hdr_idx   <= '0;
      r_is_data   <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_clr_cnt   <= '0;
      r_cpu_run   <= 1'b0;
      r_error     <= 1'b0;
      r_addr_ins  <= '0;
      r_dati_ins  <= '0;
      r_addr_data <= '0;
      r_dati_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (rx_valid) begin
          if (is_load_cmd(rx_data)) begin
            r_is_data <= (rx_data == CMD_DATA);
            r_hdr_idx <= '0;
            r_cpu_run <= 1'b0;
          end else if (rx_data == CMD_RUN) begin
            r_cpu_run <= 1'b1;
          end else if (rx_data == CMD_HALT) begin
            r_cpu_run <= 1'b0;
          end else if (rx_data == CMD_CLR) begin
            r_cpu_run <= 1'b0;
            r_clr_cnt <= CLR_LAST;
          end else begin
            r_error   <= 1'b1;
          end
        end
        S_HDR: if (rx_valid) begin
          case (r_hdr_idx)
            2'd0:    r_addr[15:8] <= rx_data;
            2'd1:    r_addr[7:0]  <= rx_data;
            2'd2:    r_cnt[15:8]  <= rx_data;
            default: r_cnt[7:0]   <= rx_data;
          endcase
          r_hdr_idx <= r_hdr_idx + 2'd1;
        end
        S_PAY_HI: if (rx_valid) r_hi <= rx_data;
        S_PAY_LO: if (rx_valid) begin
          // Bus is loaded here so it is already stable during the WRITE strobe.
          if (r_is_data) begin
            r_addr_data <= r_addr;
            r_dati_data <= {r_hi, rx_data};
          end else begin
            r_addr_ins  <= r_addr;
            r_dati_ins  <= {r_hi, rx_data};
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 16'd1;
          r_cnt  <= r_cnt - 16'd1;
          if (r_is_data ? data_memfull : ins_memfull) r_error <= 1'b1;
        end
        S_CLEAR: begin
          if (r_clr_cnt == '0) r_error   <= 1'b0;
          else                 r_clr_cnt <= r_clr_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_loader.sv
// Directed self-checking bench for hack_loader: loads, run/halt, clear,
// memfull, unknown command, zero-length frame and mid-frame reset.
module tb_hack_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        ins_memfull, data_memfull;
  logic        write_ins, write_data;
  logic [15:0] addr_ins, dati_ins, addr_data, dati_data;
  logic        mem_clr_n, cpu_reset_n, busy, error;

  int tests  = 0;
  int failed = 0;

  logic [31:0] ins_q[$];
  logic [31:0] data_q[$];

  always #5 clock = ~clock;

  hack_loader #(.CLR_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ins_memfull(ins_memfull), .data_memfull(data_memfull),
    .write_ins(write_ins), .addr_ins(addr_ins), .dati_ins(dati_ins),
    .write_data(write_data), .addr_data(addr_data), .dati_data(dati_data),
    .mem_clr_n(mem_clr_n), .cpu_reset_n(cpu_reset_n),
    .busy(busy), .error(error)
  );

  // Strobes are logged mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (write_ins)  ins_q.push_back({addr_ins, dati_ins});
    if (write_data) data_q.push_back({addr_data, dati_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [15:0] words[$]);
    logic [15:0] cnt;
    cnt = 16'(words.size());
    send_byte(cmd);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    foreach (words[i]) begin
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_entry(input string tag, input logic [31:0] q[$],
                              input int idx, input logic [31:0] exp);
    logic [31:0] obs;
    obs = (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    check(tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  {31'd0, rx_ready},    32'd0);
    check({tag, "_write_ins"}, {31'd0, write_ins},   32'd0);
    check({tag, "_write_dat"}, {31'd0, write_data},  32'd0);
    check({tag, "_buses"},     {addr_ins ^ addr_data, dati_ins | dati_data}, 32'd0);
    check({tag, "_addr_ins"},  {16'd0, addr_ins},    32'd0);
    check({tag, "_mem_clr_n"}, {31'd0, mem_clr_n},   32'd1);
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_reset_n}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},        32'd0);
    check({tag, "_error"},     {31'd0, error},       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w[$];
    int n;

    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    ins_memfull = 1'b0; data_memfull = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Instruction load of three words from address 0.
    w = '{16'h0000, 16'hFC10, 16'h0001};
    send_frame(8'h49, 16'h0000, w);
    check("ins_strobe_latency", {31'd0, write_ins}, 32'd1);
    check("ins_write_rx_ready", {31'd0, rx_ready}, 32'd0);
    idle_cycles(3);
    check("ins_count", ins_q.size(), 3);
    expect_entry("ins_w0", ins_q, 0, 32'h0000_0000);
    expect_entry("ins_w1", ins_q, 1, 32'h0001_FC10);
    expect_entry("ins_w2", ins_q, 2, 32'h0002_0001);
    check("ins_cpu_halted", {31'd0, cpu_reset_n}, 32'd0);
    check("ins_busy_done", {31'd0, busy}, 32'd0);

    // Data load then run, then halt.
    w = '{16'h000E, 16'h0014};
    send_frame(8'h44, 16'h0000, w);
    idle_cycles(3);
    check("dat_count", data_q.size(), 2);
    expect_entry("dat_w0", data_q, 0, 32'h0000_000E);
    expect_entry("dat_w1", data_q, 1, 32'h0001_0014);
    check("dat_no_ins", ins_q.size(), 3);
    check("pre_run_cpu", {31'd0, cpu_reset_n}, 32'd0);
    send_byte(8'h52);
    check("run_cpu", {31'd0, cpu_reset_n}, 32'd1);
    send_byte(8'h48);
    check("halt_cpu", {31'd0, cpu_reset_n}, 32'd0);

    // Address wrap 0xFFFF -> 0x0000.
    ins_q.delete();
    w = '{16'h1234, 16'h5678};
    send_frame(8'h49, 16'hFFFF, w);
    idle_cycles(3);
    check("wrap_count", ins_q.size(), 2);
    expect_entry("wrap_w0", ins_q, 0, 32'hFFFF_1234);
    expect_entry("wrap_w1", ins_q, 1, 32'h0000_5678);

    // Data memory full: frame consumed, no strobes, sticky error.
    data_q.delete();
    data_memfull = 1'b1;
    w = '{16'hAAAA, 16'hBBBB};
    send_frame(8'h44, 16'h0010, w);
    idle_cycles(3);
    data_memfull = 1'b0;
    check("full_no_writes", data_q.size(), 0);
    check("full_error", {31'd0, error}, 32'd1);
    check("full_busy_done", {31'd0, busy}, 32'd0);

    // Clear: mem_clr_n low for 4 cycles, error cleared at the end.
    send_byte(8'h43);
    check("clr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
    check("clr_cpu_halted", {31'd0, cpu_reset_n}, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_clr_n) break;
      n++;
    end
    check("clr_low_cycles", n, 4);
    check("clr_error_cleared", {31'd0, error}, 32'd0);
    check("clr_rx_ready_back", {31'd0, rx_ready}, 32'd1);

    // Unknown command byte, then a zero-length frame.
    send_byte(8'h00);
    check("unk_error", {31'd0, error}, 32'd1);
    check("unk_busy", {31'd0, busy}, 32'd0);
    ins_q.delete();
    data_q.delete();
    w = {};
    send_frame(8'h49, 16'h0005, w);
    check("cnt0_busy", {31'd0, busy}, 32'd0);
    idle_cycles(2);
    check("cnt0_no_strobes", ins_q.size() + data_q.size(), 0);
    check("hold_addr_ins", {16'd0, addr_ins}, 32'h0000_0000);
    check("hold_dati_ins", {16'd0, dati_ins}, 32'h0000_5678);

    // Reset after the hi byte of a payload word.
    send_byte(8'h49); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    check("midrst_no_strobe", ins_q.size(), 0);
    w = '{16'h9ABC};
    send_frame(8'h49, 16'h0030, w);
    idle_cycles(3);
    check("post_rst_count", ins_q.size(), 1);
    expect_entry("post_rst_w0", ins_q, 0, 32'h0030_9ABC);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
